// File: rtl/floo_dst_resolve_stage.sv
// -----------------------------------------------------------------------------
// floo_dst_resolve_stage
//
// Registered stage behind the address-to-endpoint-ID translation in the
// chimney request path. Each accepted request (destination ID, multicast
// masks, decode-error flag, transaction tag) is written into an in-order
// circular buffer. The head entry is dispatched either to the flit header
// assembly (good decode) or to the local error responder (decode error), in
// strict arrival order. The stage cuts the combinational path between the
// address decoder and the header/router logic.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_*  / dst_id_i ...    incoming request plus translation results
//   req_ready_o              registered-only accept (count < Depth)
//   hdr_*                    header-side handshake and fields
//   err_*                    error-response handshake and failing tag
//   err_cnt_o                saturating count of accepted decode errors
// -----------------------------------------------------------------------------
module floo_dst_resolve_stage #(
    parameter int unsigned IdWidth     = 8,
    parameter int unsigned MaskWidth   = 4,
    parameter int unsigned TxnIdWidth  = 6,
    parameter int unsigned Depth       = 2,
    parameter int unsigned ErrCntWidth = 8,
    parameter bit          EnMultiCast = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [TxnIdWidth-1:0]  req_txn_id_i,
    input  logic [IdWidth-1:0]     dst_id_i,
    input  logic [MaskWidth-1:0]   mask_x_i,
    input  logic [MaskWidth-1:0]   mask_y_i,
    input  logic                   dec_err_i,
    output logic                   hdr_valid_o,
    input  logic                   hdr_ready_i,
    output logic [IdWidth-1:0]     hdr_dst_id_o,
    output logic [MaskWidth-1:0]   hdr_mask_x_o,
    output logic [MaskWidth-1:0]   hdr_mask_y_o,
    output logic                   hdr_mcast_o,
    output logic [TxnIdWidth-1:0]  hdr_txn_id_o,
    output logic                   err_valid_o,
    input  logic                   err_ready_i,
    output logic [TxnIdWidth-1:0]  err_txn_id_o,
    output logic [ErrCntWidth-1:0] err_cnt_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    typedef struct packed {
        logic [IdWidth-1:0]    dst_id;
        logic [MaskWidth-1:0]  mask_x;
        logic [MaskWidth-1:0]  mask_y;
        logic                  err;
        logic [TxnIdWidth-1:0] txn_id;
    } entry_t;

    entry_t                 mem_q [Depth];
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]        count_q, count_d;
    logic                   ready_q, ready_d;
    logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;

    entry_t head, new_entry;
    logic   empty, push, pop, head_good, head_err;

    // Pointers wrap modulo Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) return '0;
        return p + PtrW'(1);
    endfunction

    assign head      = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign head_good = !empty && !head.err;
    assign head_err  = !empty && head.err;

    assign push = req_valid_i && ready_q;
    assign pop  = (head_good && hdr_ready_i) || (head_err && err_ready_i);

    // Failed decodes carry no meaningful routing info, so store zeros.
    always_comb begin
        new_entry        = '0;
        new_entry.err    = dec_err_i;
        new_entry.txn_id = req_txn_id_i;
        if (!dec_err_i) begin
            new_entry.dst_id = dst_id_i;
            if (EnMultiCast) begin
                new_entry.mask_x = mask_x_i;
                new_entry.mask_y = mask_y_i;
            end
        end
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        if (push && dec_err_i && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ErrCntWidth'(1);
        // Ready is computed from next-state occupancy and registered, so it
        // never depends combinationally on the downstream ready inputs. A
        // pop while full therefore only re-opens the input one cycle later.
        ready_d = (count_d < CntW'(Depth));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b0;
            err_cnt_q <= '0;
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            err_cnt_q <= err_cnt_d;
            if (push) mem_q[wr_ptr_q] <= new_entry;
        end
    end

    assign req_ready_o  = ready_q;
    assign hdr_valid_o  = head_good;
    assign err_valid_o  = head_err;
    // Data outputs are zeroed while their valid is low.
    assign hdr_dst_id_o = head_good ? head.dst_id : '0;
    assign hdr_mask_x_o = head_good ? head.mask_x : '0;
    assign hdr_mask_y_o = head_good ? head.mask_y : '0;
    assign hdr_txn_id_o = head_good ? head.txn_id : '0;
    assign hdr_mcast_o  = head_good && EnMultiCast && ((head.mask_x != '0) || (head.mask_y != '0));
    assign err_txn_id_o = head_err ? head.txn_id : '0;
    assign err_cnt_o    = err_cnt_q;

`ifndef SYNTHESIS
    a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_valid_i && !req_ready_o) |=> (req_valid_i &&
        $stable({req_txn_id_i, dst_id_i, mask_x_i, mask_y_i, dec_err_i})));
    a_one_hot_out : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(hdr_valid_o && err_valid_o));
    a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CntW'(Depth));
`endif

endmodule

// File: tb/tb_floo_dst_resolve_stage.sv
module tb_floo_dst_resolve_stage;

    // Instance A: multicast enabled, 2-bit error counter.
    // Instance B: defaults (multicast disabled, 8-bit counter).
    // Both share all inputs and have the same depth, so handshakes line up.
    logic       clk = 1'b0;
    logic       rst_ni;
    logic       req_valid_i;
    logic [5:0] req_txn_id_i;
    logic [7:0] dst_id_i;
    logic [3:0] mask_x_i, mask_y_i;
    logic       dec_err_i;
    logic       hdr_ready_i, err_ready_i;

    logic       a_req_ready_o, a_hdr_valid_o, a_hdr_mcast_o, a_err_valid_o;
    logic [7:0] a_hdr_dst_id_o;
    logic [3:0] a_hdr_mask_x_o, a_hdr_mask_y_o;
    logic [5:0] a_hdr_txn_id_o, a_err_txn_id_o;
    logic [1:0] a_err_cnt_o;

    logic       b_req_ready_o, b_hdr_valid_o, b_hdr_mcast_o, b_err_valid_o;
    logic [7:0] b_hdr_dst_id_o;
    logic [3:0] b_hdr_mask_x_o, b_hdr_mask_y_o;
    logic [5:0] b_hdr_txn_id_o, b_err_txn_id_o;
    logic [7:0] b_err_cnt_o;

    always #5 clk = ~clk;

    floo_dst_resolve_stage #(.Depth(2), .EnMultiCast(1'b1), .ErrCntWidth(2)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(a_req_ready_o),
        .req_txn_id_i(req_txn_id_i), .dst_id_i(dst_id_i),
        .mask_x_i(mask_x_i), .mask_y_i(mask_y_i), .dec_err_i(dec_err_i),
        .hdr_valid_o(a_hdr_valid_o), .hdr_ready_i(hdr_ready_i),
        .hdr_dst_id_o(a_hdr_dst_id_o), .hdr_mask_x_o(a_hdr_mask_x_o),
        .hdr_mask_y_o(a_hdr_mask_y_o), .hdr_mcast_o(a_hdr_mcast_o),
        .hdr_txn_id_o(a_hdr_txn_id_o),
        .err_valid_o(a_err_valid_o), .err_ready_i(err_ready_i),
        .err_txn_id_o(a_err_txn_id_o), .err_cnt_o(a_err_cnt_o)
    );

    floo_dst_resolve_stage u_dut_b (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(b_req_ready_o),
        .req_txn_id_i(req_txn_id_i), .dst_id_i(dst_id_i),
        .mask_x_i(mask_x_i), .mask_y_i(mask_y_i), .dec_err_i(dec_err_i),
        .hdr_valid_o(b_hdr_valid_o), .hdr_ready_i(hdr_ready_i),
        .hdr_dst_id_o(b_hdr_dst_id_o), .hdr_mask_x_o(b_hdr_mask_x_o),
        .hdr_mask_y_o(b_hdr_mask_y_o), .hdr_mcast_o(b_hdr_mcast_o),
        .hdr_txn_id_o(b_hdr_txn_id_o),
        .err_valid_o(b_err_valid_o), .err_ready_i(err_ready_i),
        .err_txn_id_o(b_err_txn_id_o), .err_cnt_o(b_err_cnt_o)
    );

    typedef struct {
        bit         err;
        logic [7:0] dst;
        logic [3:0] mx;
        logic [3:0] my;
        logic [5:0] txn;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   exp_cnt_a = 0;
    int   exp_cnt_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: samples 1 time unit after each falling edge, after the
    // stimulus has settled, and pops the scoreboard on every handshake.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (rst_ni === 1'b1) begin
            chk("excl_a", 32'(a_hdr_valid_o & a_err_valid_o), 0);
            if ((a_hdr_valid_o && hdr_ready_i) || (a_err_valid_o && err_ready_i)) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    pop_cyc.push_back(cyc);
                    chk("kind_err", 32'(a_err_valid_o), 32'(e.err));
                    if (!e.err) begin
                        chk("hdr_dst_a", 32'(a_hdr_dst_id_o), 32'(e.dst));
                        chk("hdr_mx_a", 32'(a_hdr_mask_x_o), 32'(e.mx));
                        chk("hdr_my_a", 32'(a_hdr_mask_y_o), 32'(e.my));
                        chk("hdr_mc_a", 32'(a_hdr_mcast_o), 32'((e.mx != 0) || (e.my != 0)));
                        chk("hdr_txn_a", 32'(a_hdr_txn_id_o), 32'(e.txn));
                        chk("hdr_vld_b", 32'(b_hdr_valid_o), 1);
                        chk("hdr_dst_b", 32'(b_hdr_dst_id_o), 32'(e.dst));
                        chk("hdr_mask_b", 32'({b_hdr_mask_x_o, b_hdr_mask_y_o}), 0);
                        chk("hdr_mc_b", 32'(b_hdr_mcast_o), 0);
                        chk("hdr_txn_b", 32'(b_hdr_txn_id_o), 32'(e.txn));
                    end else begin
                        chk("err_txn_a", 32'(a_err_txn_id_o), 32'(e.txn));
                        chk("err_vld_b", 32'(b_err_valid_o), 1);
                        chk("err_txn_b", 32'(b_err_txn_id_o), 32'(e.txn));
                    end
                end
            end
        end
    end

    // Call at a falling edge. Holds the request until accepted, records the
    // expected result, then checks both error counters against the model.
    task automatic push(input logic [5:0] txn, input logic [7:0] dst,
                        input logic [3:0] mx, input logic [3:0] my, input bit err);
        exp_t e;
        int   w = 0;
        req_valid_i  = 1'b1;
        req_txn_id_i = txn;
        dst_id_i     = dst;
        mask_x_i     = mx;
        mask_y_i     = my;
        dec_err_i    = err;
        while (!a_req_ready_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("push_timeout", 32'(w < 50), 1);
        e.err = err;
        e.dst = err ? 8'h00 : dst;
        e.mx  = err ? 4'h0 : mx;
        e.my  = err ? 4'h0 : my;
        e.txn = txn;
        sb.push_back(e);
        @(negedge clk);
        req_valid_i = 1'b0;
        if (err) begin
            exp_cnt_a = (exp_cnt_a == 3)   ? 3   : exp_cnt_a + 1;
            exp_cnt_b = (exp_cnt_b == 255) ? 255 : exp_cnt_b + 1;
        end
        chk("cnt_a", 32'(a_err_cnt_o), 32'(exp_cnt_a));
        chk("cnt_b", 32'(b_err_cnt_o), 32'(exp_cnt_b));
    endtask

    initial begin
        int t0;
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        req_txn_id_i = '0;
        dst_id_i     = '0;
        mask_x_i     = '0;
        mask_y_i     = '0;
        dec_err_i    = 1'b0;
        hdr_ready_i  = 1'b0;
        err_ready_i  = 1'b0;

        // Reset state
        #3;
        chk("rst_ready", 32'(a_req_ready_o), 0);
        chk("rst_hdr_vld", 32'(a_hdr_valid_o), 0);
        chk("rst_err_vld", 32'(a_err_valid_o), 0);
        chk("rst_cnt", 32'(b_err_cnt_o), 0);
        chk("rst_data", 32'({a_hdr_dst_id_o, a_hdr_txn_id_o, a_err_txn_id_o}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("ready_lag", 32'(a_req_ready_o), 0);
        @(negedge clk);
        chk("ready_after_rst", 32'(a_req_ready_o), 1);

        // Streaming: one per cycle, first header one cycle after accept
        hdr_ready_i = 1'b1;
        err_ready_i = 1'b1;
        pop_cyc.delete();
        push(6'd1, 8'h11, 4'h0, 4'h0, 1'b0);
        chk("stream_first_vld", 32'(a_hdr_valid_o), 1);
        push(6'd2, 8'h22, 4'h0, 4'h0, 1'b0);
        push(6'd3, 8'h33, 4'h0, 4'h0, 1'b0);
        push(6'd4, 8'h44, 4'h0, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk("stream_pops", 32'(pop_cyc.size()), 4);
        if (pop_cyc.size() == 4) chk("stream_rate", 32'(pop_cyc[3] - pop_cyc[0]), 3);

        // Backpressure / full
        hdr_ready_i = 1'b0;
        push(6'd5, 8'h11, 4'h0, 4'h0, 1'b0);
        push(6'd6, 8'h22, 4'h0, 4'h0, 1'b0);
        fork
            push(6'd7, 8'h33, 4'h0, 4'h0, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("full_ready", 32'(a_req_ready_o), 0);
                    chk("full_hold_vld", 32'(a_hdr_valid_o), 1);
                    chk("full_hold_dst", 32'(a_hdr_dst_id_o), 32'h11);
                end
                hdr_ready_i = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        chk("full_drained", 32'(sb.size()), 0);

        // Multicast: A forwards masks, B zeroes them
        push(6'd8, 8'h55, 4'b0011, 4'b0000, 1'b0);
        push(6'd9, 8'h66, 4'b0000, 4'b1000, 1'b0);
        push(6'd10, 8'h77, 4'b0000, 4'b0000, 1'b0);
        repeat (3) @(negedge clk);

        // Error ordering: error head blocks the following good entry
        err_ready_i = 1'b0;
        push(6'd1, 8'h10, 4'h0, 4'h0, 1'b0);
        push(6'd2, 8'hAA, 4'h5, 4'h5, 1'b1);
        push(6'd3, 8'h30, 4'h0, 4'h0, 1'b0);
        repeat (5) begin
            chk("err_hold_vld", 32'(a_err_valid_o), 1);
            chk("err_hold_txn", 32'(a_err_txn_id_o), 2);
            chk("err_blocks_hdr", 32'(a_hdr_valid_o), 0);
            @(negedge clk);
        end
        chk("err_pending", 32'(sb.size()), 2);
        err_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("err_drained", 32'(sb.size()), 0);
        chk("err_cnt_one", 32'(b_err_cnt_o), 1);

        // Reset mid-operation with two entries pending
        hdr_ready_i = 1'b0;
        push(6'd11, 8'h71, 4'h0, 4'h0, 1'b0);
        push(6'd12, 8'h72, 4'h0, 4'h0, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_hdr", 32'(a_hdr_valid_o), 0);
        chk("mid_rst_err", 32'(a_err_valid_o), 0);
        chk("mid_rst_cnt_a", 32'(a_err_cnt_o), 0);
        chk("mid_rst_cnt_b", 32'(b_err_cnt_o), 0);
        chk("mid_rst_ready", 32'(a_req_ready_o), 0);
        sb.delete();
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(a_req_ready_o), 1);
        chk("post_rst_empty", 32'(a_hdr_valid_o | a_err_valid_o), 0);
        hdr_ready_i = 1'b1;
        push(6'd13, 8'h99, 4'h0, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk("post_rst_drained", 32'(sb.size()), 0);

        // Counter saturation (A: 2-bit -> 1,2,3,3,3)
        err_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) push(6'(20 + i), 8'hE0, 4'h0, 4'h0, 1'b1);

        // Final drain, bounded
        t0 = 0;
        while (sb.size() != 0 && t0 < 20) begin
            @(negedge clk);
            t0++;
        end
        chk("final_drain", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/floo_dst_resolve_stage.md
Name: floo_dst_resolve_stage

Overview:
- Registered stage directly downstream of the address-to-endpoint-ID translation in the chimney request path.
- Captures each request's translated destination ID, multicast masks and decode-error flag in an in-order elastic buffer.
- Forwards valid destinations to the flit header assembly; diverts decode errors to a local error-response port so the requester gets a DECERR instead of a flit entering the network.
- Breaks the combinational path from address decode to header/router logic.

Parameters:
- IdWidth, 8, width of destination endpoint ID.
- MaskWidth, 4, width of each multicast mask (x and y).
- TxnIdWidth, 6, width of the transaction tag carried alongside the request.
- Depth, 2, buffer entries; legal range 1..8, and 2 gives full throughput.
- ErrCntWidth, 8, width of the saturating decode-error counter.
- EnMultiCast, 1'b0, when 0 the masks are ignored and forced to 0.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid, with translation results valid in the same cycle
- req_ready_o  out  1  stage can accept a request
- req_txn_id_i  in  TxnIdWidth  transaction tag
- dst_id_i  in  IdWidth  translated destination ID
- mask_x_i  in  MaskWidth  multicast x mask
- mask_y_i  in  MaskWidth  multicast y mask
- dec_err_i  in  1  address did not match any rule
- hdr_valid_o  out  1  header entry valid
- hdr_ready_i  in  1  header consumer ready
- hdr_dst_id_o  out  IdWidth  destination ID
- hdr_mask_x_o  out  MaskWidth  x mask
- hdr_mask_y_o  out  MaskWidth  y mask
- hdr_mcast_o  out  1  multicast request
- hdr_txn_id_o  out  TxnIdWidth  tag
- err_valid_o  out  1  error response request valid
- err_ready_i  in  1  error responder ready
- err_txn_id_o  out  TxnIdWidth  tag of the failed request
- err_cnt_o  out  ErrCntWidth  saturating count of decode errors accepted

Behaviour:
- Reset (rst_ni low, asynchronous):
  - Buffer empty; read and write pointers 0; count 0.
  - hdr_valid_o=0, err_valid_o=0, err_cnt_o=0, all data outputs 0.
  - req_ready_o=1 one cycle after reset deasserts; req_ready_o=0 while in reset.
- Reset asserted mid-operation discards all entries; no pending output is completed.
- Buffer:
  - Circular FIFO of Depth entries; each entry holds {dst_id, mask_x, mask_y, err, txn_id}.
  - req_ready_o = (count < Depth). It depends only on registered state and never on hdr_ready_i or err_ready_i.
- Push happens when req_valid_i && req_ready_o. Captured fields:
  - err = dec_err_i.
  - If EnMultiCast=0, masks are stored as 0.
  - If dec_err_i=1, dst_id and masks are stored as 0.
- Latency: an accepted request appears at the head no earlier than the next cycle. There is no combinational bypass.
- Head dispatch:
  - hdr_valid_o = !empty && !head.err.
  - err_valid_o = !empty && head.err.
  - At most one of hdr_valid_o and err_valid_o is high in any cycle.
  - Order is strict: an error entry at the head blocks later good entries until err_ready_i, and the reverse also holds.
- Pop happens on (hdr_valid_o && hdr_ready_i) || (err_valid_o && err_ready_i). The read pointer advances and wraps modulo Depth.
- Outputs are stable while their valid is high and not accepted; each valid stays asserted until its handshake completes.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
  - When full, a same-cycle pop does NOT enable a push, because ready is registered-only.
  - Depth=1 therefore sustains half throughput.
- hdr_mcast_o = EnMultiCast && (hdr_mask_x_o != 0 || hdr_mask_y_o != 0); it is 0 when hdr_valid_o=0.
- err_cnt_o:
  - Increments by 1 on each push with dec_err_i=1.
  - Saturates at all-ones and does not wrap; cleared only by reset.
- Data outputs when the corresponding valid is 0 show the head fields or 0; the bench must not check them.
- Assertions:
  - Inputs stable while req_valid_i && !req_ready_o.
  - Never hdr_valid_o && err_valid_o.
  - Count never exceeds Depth.

Test Plan:
- Streaming: Depth=2, push 4 requests with dst_id 0x11,0x22,0x33,0x44 back-to-back, hdr_ready_i=1 -> first hdr_valid_o one cycle after the first accept, then IDs in order at one per cycle, err_valid_o never high.
- Backpressure/full: hdr_ready_i=0, push 3 requests -> first two accepted, req_ready_o=0 from then on, third held; set hdr_ready_i=1 -> drain 0x11,0x22, then third accepted, with no loss or duplication.
- Error ordering: push good(txn 1), err(txn 2), good(txn 3), with err_ready_i=0 for 5 cycles -> txn 1 on hdr; err_valid_o=1 with err_txn_id_o=2 held 5 cycles; txn 3 does not appear on hdr until the error handshake completes; err_cnt_o=1.
- Multicast: EnMultiCast=1, mask_x_i=4'b0011, mask_y_i=0 -> hdr_mcast_o=1 with masks forwarded; repeat with EnMultiCast=0 -> masks 0 and hdr_mcast_o=0.
- Counter saturation: ErrCntWidth=2, push 5 errors with err_ready_i=1 -> err_cnt_o goes 1,2,3,3,3.
- Reset mid-operation: 2 entries pending, assert rst_ni asynchronously between clock edges -> hdr_valid_o, err_valid_o and err_cnt_o go to 0 immediately; after release the buffer is empty and the next push is delivered correctly.
